// File: rtl/instruction_memory_responder.sv
// Fetch-side instruction responder: read-only word array returning in-order responses
// after a fixed latency, with consumer backpressure and a single-cycle flush.
module instruction_memory_responder #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_address,
  output logic                  resp_error,
  output logic                  busy
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic                  err;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                         active_q;
  logic [CNT_W-1:0]             outstanding_q;
  logic                         req_fire;
  logic                         resp_fire;
  logic                         addr_err;
  logic [ADDR_WIDTH-3:0]        word_idx;
  entry_t                       new_entry;
  logic                         arrive_valid;
  entry_t                       arrive_entry;
  entry_t [MAX_OUTSTANDING-1:0] q_mem_q;
  logic [PTR_W-1:0]             rd_ptr_q;
  logic [PTR_W-1:0]             wr_ptr_q;
  logic [CNT_W-1:0]             q_cnt_q;
  logic                         q_push;
  entry_t                       q_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign req_ready  = active_q & (outstanding_q < CNT_W'(MAX_OUTSTANDING)) & ~flush;
  assign resp_valid = (q_cnt_q != '0) & ~flush;
  assign req_fire   = req_valid & req_ready;
  assign resp_fire  = resp_valid & resp_ready;
  assign busy       = (outstanding_q != '0);

  assign q_head       = q_mem_q[rd_ptr_q];
  assign resp_data    = q_head.data;
  assign resp_address = q_head.addr;
  assign resp_error   = q_head.err;

  // Address decode and array lookup for the request presented this cycle.
  assign word_idx = req_address[ADDR_WIDTH-1:2];
  assign addr_err = (req_address[1:0] != 2'b00) || (word_idx >= (ADDR_WIDTH-2)'(DEPTH_WORDS));

  always_comb begin
    new_entry.err  = addr_err;
    new_entry.addr = req_address;
    new_entry.data = addr_err ? NOP_WORD : mem[word_idx[IDX_W-1:0]];
  end

  // Fixed-latency shift: the last stage lands in the queue one cycle before it is visible.
  if (LATENCY == 1) begin : g_direct
    assign arrive_valid = req_fire;
    assign arrive_entry = new_entry;
  end else begin : g_pipe
    localparam int unsigned STAGES = LATENCY - 1;
    logic [STAGES-1:0]   stage_valid_q;
    entry_t [STAGES-1:0] stage_entry_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stage_valid_q <= '0;
        stage_entry_q <= '0;
      end else begin
        stage_valid_q <= flush ? '0 : STAGES'({stage_valid_q, req_fire});
        stage_entry_q <= (STAGES*ENTRY_W)'({stage_entry_q, new_entry});
      end
    end

    assign arrive_valid = stage_valid_q[STAGES-1];
    assign arrive_entry = stage_entry_q[STAGES-1];
  end

  assign q_push = arrive_valid & ~flush;

  // Response queue; the outstanding limit keeps it from overflowing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_mem_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      q_cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      if (q_push) begin
        q_mem_q[wr_ptr_q] <= arrive_entry;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (resp_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
      q_cnt_q <= q_cnt_q + CNT_W'(q_push) - CNT_W'(resp_fire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q      <= 1'b0;
      outstanding_q <= '0;
    end else begin
      active_q <= 1'b1;
      if (flush) begin
        outstanding_q <= '0;
      end else begin
        unique case ({req_fire, resp_fire})
          2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
          2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
          default: outstanding_q <= outstanding_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench for instruction_memory_responder: directed scenarios plus random
// traffic checked against an address-rule reference model.
module tb_instruction_memory_responder;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned MAXO  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_address = '0;
  logic          flush = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] resp_address;
  logic          resp_error;
  logic          busy;

  instruction_memory_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_address(resp_address),
    .resp_error(resp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rom [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        tb_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Requests are only accepted from the first edge after reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_active <= 1'b0;
    else        tb_active <= 1'b1;
  end

  task automatic check_bit(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic exp_t ref_resp(input logic [31:0] a, input int acc);
    exp_t        e;
    int unsigned idx;
    idx    = a / 4;
    e.addr = a;
    e.acc  = acc;
    e.err  = (a % 4 != 0) || (idx >= DEPTH);
    if (e.err) e.data = 32'h0000_0013;
    else       e.data = rom[idx];
    return e;
  endfunction

  task automatic cycle_do(input logic v, input logic [31:0] a, input logic f,
                          input logic rr, output logic fired);
    @(posedge clk); #1;
    req_valid   = v;
    req_address = a;
    flush       = f;
    resp_ready  = rr;
    @(negedge clk);
    fired = v && req_ready;
    if (fired) exp_q.push_back(ref_resp(a, cyc));
    if (f) exp_q.delete();
  endtask

  // Monitor: handshake model, hold stability, and in-order scoreboard pops.
  initial begin
    int          model_cnt;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [31:0] prev_addr;
    logic        prev_err;
    exp_t        e;
    model_cnt  = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_addr  = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_bit("rst_req_ready", req_ready, 1'b0);
        check_bit("rst_resp_valid", resp_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        model_cnt  = 0;
        prev_stall = 1'b0;
      end else begin
        check_bit("req_ready", req_ready, tb_active && (model_cnt < MAXO) && !flush);
        check_bit("busy", busy, model_cnt != 0);
        if (flush) check_bit("flush_resp_valid", resp_valid, 1'b0);
        if (prev_stall && !flush) begin
          check_bit("hold_valid", resp_valid, 1'b1);
          check_word("hold_data", resp_data, prev_data);
          check_word("hold_addr", resp_address, prev_addr);
          check_bit("hold_err", resp_error, prev_err);
        end
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got response for %h, expected none (cycle %0d)",
                     resp_address, cyc);
          end else begin
            e = exp_q.pop_front();
            check_word("sb_addr", resp_address, e.addr);
            check_word("sb_data", resp_data, e.data);
            check_bit("sb_err", resp_error, e.err);
            check_bit("sb_latency", (cyc - e.acc) >= int'(LAT), 1'b1);
          end
        end
        prev_stall = resp_valid && !resp_ready;
        prev_data  = resp_data;
        prev_addr  = resp_address;
        prev_err   = resp_error;
        if (flush) model_cnt = 0;
        else model_cnt = model_cnt + int'(req_valid && req_ready) - int'(resp_valid && resp_ready);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        f;
    logic        v;
    logic        fl;
    logic        rr;
    logic [31:0] a;
    int unsigned r;

    for (int i = 0; i < int'(DEPTH); i++) begin
      rom[i]     = $urandom;
      dut.mem[i] = rom[i];
    end
    rom[0]     = 32'h0050_0093;
    dut.mem[0] = rom[0];

    repeat (2) @(negedge clk);
    check_word("rst_resp_data", resp_data, 32'h0);
    check_word("rst_resp_addr", resp_address, 32'h0);
    check_bit("rst_resp_err", resp_error, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;

    // Single request latency and busy timing.
    cycle_do(1'b1, 32'h0, 1'b0, 1'b1, f);
    check_bit("t1_accept", f, 1'b1);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t1_c1_valid", resp_valid, 1'b0);
    check_bit("t1_c1_busy", busy, 1'b1);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t1_c2_valid", resp_valid, 1'b1);
    check_word("t1_c2_data", resp_data, 32'h0050_0093);
    check_word("t1_c2_addr", resp_address, 32'h0);
    check_bit("t1_c2_err", resp_error, 1'b0);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t1_c3_busy", busy, 1'b0);
    check_bit("t1_c3_valid", resp_valid, 1'b0);

    // Back-to-back requests hit the outstanding limit.
    cycle_do(1'b1, 32'h0, 1'b0, 1'b1, f);
    cycle_do(1'b1, 32'h4, 1'b0, 1'b1, f);
    cycle_do(1'b1, 32'h8, 1'b0, 1'b1, f);
    check_bit("t2_c2_ready", req_ready, 1'b0);
    check_bit("t2_c2_valid", resp_valid, 1'b1);
    cycle_do(1'b1, 32'h8, 1'b0, 1'b1, f);
    check_bit("t2_c3_accept", f, 1'b1);
    repeat (4) cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);

    // Backpressure for five cycles, then drain.
    cycle_do(1'b1, 32'h0, 1'b0, 1'b0, f);
    cycle_do(1'b1, 32'h4, 1'b0, 1'b0, f);
    repeat (5) cycle_do(1'b0, 32'h0, 1'b0, 1'b0, f);
    check_bit("t3_stall_valid", resp_valid, 1'b1);
    check_word("t3_stall_data", resp_data, rom[0]);
    check_bit("t3_stall_ready", req_ready, 1'b0);
    check_bit("t3_stall_busy", busy, 1'b1);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t3_first_valid", resp_valid, 1'b1);
    check_word("t3_first_addr", resp_address, 32'h0);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t3_second_valid", resp_valid, 1'b1);
    check_word("t3_second_addr", resp_address, 32'h4);
    check_word("t3_second_data", resp_data, rom[1]);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t3_after_valid", resp_valid, 1'b0);

    // Flush with two requests in flight.
    cycle_do(1'b1, 32'h0, 1'b0, 1'b1, f);
    cycle_do(1'b1, 32'h4, 1'b0, 1'b1, f);
    cycle_do(1'b1, 32'h8, 1'b1, 1'b1, f);
    check_bit("t4_flush_valid", resp_valid, 1'b0);
    check_bit("t4_flush_ready", req_ready, 1'b0);
    check_bit("t4_flush_accept", f, 1'b0);
    cycle_do(1'b1, 32'h10, 1'b0, 1'b1, f);
    check_bit("t4_post_busy", busy, 1'b0);
    check_bit("t4_post_valid", resp_valid, 1'b0);
    check_bit("t4_post_accept", f, 1'b1);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t4_c1_valid", resp_valid, 1'b0);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t4_c2_valid", resp_valid, 1'b1);
    check_word("t4_c2_addr", resp_address, 32'h10);
    check_word("t4_c2_data", resp_data, rom[4]);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t4_c3_valid", resp_valid, 1'b0);

    // Misaligned and out-of-range requests.
    cycle_do(1'b1, 32'h6, 1'b0, 1'b1, f);
    cycle_do(1'b1, DEPTH * 4, 1'b0, 1'b1, f);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t5_mis_valid", resp_valid, 1'b1);
    check_bit("t5_mis_err", resp_error, 1'b1);
    check_word("t5_mis_data", resp_data, 32'h0000_0013);
    check_word("t5_mis_addr", resp_address, 32'h6);
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t5_oor_valid", resp_valid, 1'b1);
    check_bit("t5_oor_err", resp_error, 1'b1);
    check_word("t5_oor_data", resp_data, 32'h0000_0013);
    check_word("t5_oor_addr", resp_address, DEPTH * 4);

    // Asynchronous reset with a request in flight.
    cycle_do(1'b1, 32'h8, 1'b0, 1'b1, f);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_bit("t6_ready", req_ready, 1'b0);
    check_bit("t6_valid", resp_valid, 1'b0);
    check_word("t6_data", resp_data, 32'h0);
    check_word("t6_addr", resp_address, 32'h0);
    check_bit("t6_err", resp_error, 1'b0);
    check_bit("t6_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    check_bit("t6_release_ready", req_ready, 1'b1);
    repeat (6) cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 99) < 60);
      r  = $urandom_range(0, 99);
      if (r < 80)      a = $urandom_range(0, DEPTH - 1) * 4;
      else if (r < 90) a = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
      else             a = (DEPTH * 4) + ($urandom_range(0, 1000) * 4);
      fl = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 99) < 70);
      cycle_do(v, a, fl, rr, f);
    end

    repeat (20) cycle_do(1'b0, 32'h0, 1'b0, 1'b1, f);
    #1;
    check_word("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
